iib_scan_ctrl: RTL
==================

# iib_scan_ctrl

Frame-level scheduler for the integral-image buffer block (`iib`). Gates the buffer's window scan (`iRun`) against the readiness of the three window classifier engines (23x23, 19x19, 17x17). Captures each completed window's scale and search-map address, dispatches it to the matching engine, and drains and rearms the buffer at end of frame. Sits between the frame loader, the `iib` instance and the classifier engines.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 4095: maximum cycles in WAIT_FIN before a timeout error.
- `CNT_W`, default 13: width of the per-scale window counters.

Ports:
- `iClk`  in  1  single clock; all state changes on its rising edge.
- `iReset_n`  in  1  asynchronous, active-low reset.
- `iFrame_start`  in  1  one-cycle pulse: the search map and the IIB RAM for a new 80x60 frame are loaded.
- `iAbort`  in  1  one-cycle pulse: abandon the current frame.
- `oRun`  out  1  to `iib.iRun`.
- `oRst`  out  1  to `iib.iRst`; one-cycle pulse.
- `iFinish`  in  2  from `iib.oFinish`: 3 = 23x23, 2 = 19x19, 1 = 17x17, 0 = none.
- `iEnd`  in  1  from `iib.oEnd`: last window of the frame has been streamed.
- `iAddr_OM`  in  13  from `iib.oAddr_OM`: search-map address of the current window.
- `iReady_23`, `iReady_19`, `iReady_17`  in  1 each  the engine can accept a window.
- `oStart_23`, `oStart_19`, `oStart_17`  out  1 each  one-cycle dispatch pulse.
- `oWin_addr`  out  13  captured window address; valid while a start pulse is high.
- `oFrame_done`  out  1  one-cycle pulse when a frame completes normally.
- `oCnt_23`, `oCnt_19`, `oCnt_17`  out  CNT_W each  windows dispatched this frame, saturating.
- `oTimeout`  out  1  sticky flag; cleared by `iFrame_start`.
- `oOverrun`  out  1  sticky flag; cleared by `iFrame_start` accepted in IDLE.
- `oBusy`  out  1  high in every state except IDLE.

## Operation
- **States:** IDLE, ARM, WAIT_FIN, DISPATCH, DRAIN, RST, DONE.
- **IDLE:**
  - On `iFrame_start`: clear the counters and sticky flags, then go to ARM.
- **ARM:**
  - When all three `iReady_*` are high: set `oRun` to 1 and go to WAIT_FIN.
- **WAIT_FIN:**
  - On `iFinish != 0`: capture `iFinish` into a scale register and `iAddr_OM` into `oWin_addr`, set `oRun` to 0, and go to DISPATCH.
  - A watchdog counts the cycles spent here. When it reaches `TIMEOUT_CYC`, set `oTimeout` and go to RST.
- **DISPATCH:**
  - When the selected engine's `iReady_*` is high: pulse its `oStart_*` for one cycle and increment its counter, saturating at 2^CNT_W−1.
  - If the end flag is set, go to DRAIN; otherwise go to ARM.
- **End-of-frame flag:**
  - `iEnd` seen in any state from ARM through DISPATCH latches an internal end flag.
  - If `iEnd` and `iFinish` arrive in the same cycle, dispatch the window first, then drain.
- **DRAIN:**
  - When all `iReady_*` are high, go to RST.
- **RST:**
  - Pulse `oRst` for exactly one cycle.
  - Go to DONE after a normal end; go to IDLE after an abort or timeout.
- **DONE:**
  - Pulse `oFrame_done` for one cycle, then go to IDLE.
- **`iAbort`:**
  - From any non-IDLE state: set `oRun` to 0, drop any pending dispatch without issuing a start, and go to RST.
  - No `oFrame_done` is produced.
- **`iFrame_start` while not IDLE:** ignored, and `oOverrun` is set.
- **Scale codes:** decode exactly as listed under `iFinish`; a code of 0 is never captured.

## Timing
- **Reset values:**
  - All outputs are 0, including `oRun`, `oRst`, `oStart_*`, `oFrame_done`, the counters, `oTimeout`, `oOverrun` and `oBusy`.
  - `oWin_addr` resets to 13'd0 and the state resets to IDLE.
  - Asserting reset mid-frame returns to IDLE immediately, with no `oRst` pulse.
- **Registered outputs:** every output is registered; there are no combinational input-to-output paths.
- **`oRun` release:** `oRun` falls on the edge after the cycle in which `iFinish != 0` is sampled. This prevents `iib` from re-entering its scan in the cycle after its finish pulse clears.
- **Dispatch latency:** the start pulse appears at least 1 cycle after `iFinish`; it is exactly 1 cycle when the target engine is already ready.
- **Re-arm:** `oRun` rises again no earlier than 1 cycle after the start pulse.
- **Watchdog:** the counter restarts on every entry to WAIT_FIN. The timeout fires on the cycle the count equals `TIMEOUT_CYC`.
- **End-of-frame sequence:** `oRst` is high for 1 cycle and `oFrame_done` is high on the following cycle.

## Structure
- **Package `iib_pkg`:**
  - The state enumeration.
  - The scale codes: SCALE_23 = 3, SCALE_19 = 2, SCALE_17 = 1.
  - `END_IIB_VAL` = 4799 and the frame dimensions, 80x60.
- **Sub-module `iib_win_counter`:** a saturating counter with clear and increment inputs. The block instantiates it three times, one per scale.

## Test plan
- **Single frame, one window:**
  - Stimulus: `iFrame_start` with all engines ready, then `iFinish = 3` with `iAddr_OM = 729` 10 cycles later.
  - Required response: `oRun` low the next cycle; one `oStart_23` pulse with `oWin_addr = 729`; `oCnt_23 = 1`; `oRun` high again.
- **Back-pressure:**
  - Stimulus: `iFinish = 1` while `iReady_17` stays low for 20 cycles.
  - Required response: no `oStart_17` and `oRun` stays low until `iReady_17` rises; then exactly one `oStart_17` pulse.
- **Simultaneous end:**
  - Stimulus: `iFinish = 2` and `iEnd` in the same cycle.
  - Required response: in order, one `oStart_19`, then a 1-cycle `oRst`, then a 1-cycle `oFrame_done`, then `oBusy = 0`.
- **Timeout:**
  - Stimulus: `TIMEOUT_CYC` = 16 and no `iFinish` after arming.
  - Required response: `oTimeout` set 16 cycles after WAIT_FIN entry; `oRst` pulses; state returns to IDLE with no `oFrame_done`.
- **Abort and overrun:**
  - Stimulus: `iAbort` in DISPATCH, then `iFrame_start` while in RST.
  - Required response: no `oStart_*` is issued; `oRst` pulses; `oOverrun` = 1.
- **Reset mid-frame:**
  - Stimulus: drop `iReset_n` in WAIT_FIN, between clock edges.
  - Required response: all outputs 0 immediately, without waiting for a clock edge; after release, state is IDLE.

Source files
------------

// File: rtl/iib_pkg.sv
// iib_pkg: shared states, scale codes and frame geometry for the iib scan controller
package iib_pkg;
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_WAIT_FIN,
    ST_DISPATCH,
    ST_DRAIN,
    ST_RST,
    ST_DONE
  } state_t;
  localparam logic [1:0] SCALE_23 = 2'd3;
  localparam logic [1:0] SCALE_19 = 2'd2;
  localparam logic [1:0] SCALE_17 = 2'd1;
  localparam int FRAME_W = 80;
  localparam int FRAME_H = 60;
  localparam int END_IIB_VAL = FRAME_W * FRAME_H - 1;
  // one-hot engine select ordered {23, 19, 17}; code 0 selects nothing
  function automatic logic [2:0] scale_onehot(input logic [1:0] s);
    return {s == SCALE_23, s == SCALE_19, s == SCALE_17};
  endfunction
endpackage

// File: rtl/iib_win_counter.sv
// iib_win_counter: saturating per-scale window counter with synchronous clear
module iib_win_counter #(
  parameter int W = 13
) (
  input  logic         iClk,
  input  logic         iReset_n,
  input  logic         iClr,
  input  logic         iInc,
  output logic [W-1:0] oCnt
);
  // clear wins over increment; hold at all-ones once saturated
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) oCnt <= '0;
    else if (iClr) oCnt <= '0;
    else if (iInc && oCnt != '1) oCnt <= oCnt + 1'b1;
  end
endmodule

// File: rtl/iib_scan_ctrl.sv
// iib_scan_ctrl: gates the iib window scan against engine readiness and dispatches windows
module iib_scan_ctrl
  import iib_pkg::*;
#(
  parameter int TIMEOUT_CYC = 4095,
  parameter int CNT_W = 13
) (
  input  logic             iClk,
  input  logic             iReset_n,
  input  logic             iFrame_start,
  input  logic             iAbort,
  output logic             oRun,
  output logic             oRst,
  input  logic [1:0]       iFinish,
  input  logic             iEnd,
  input  logic [12:0]      iAddr_OM,
  input  logic             iReady_23,
  input  logic             iReady_19,
  input  logic             iReady_17,
  output logic             oStart_23,
  output logic             oStart_19,
  output logic             oStart_17,
  output logic [12:0]      oWin_addr,
  output logic             oFrame_done,
  output logic [CNT_W-1:0] oCnt_23,
  output logic [CNT_W-1:0] oCnt_19,
  output logic [CNT_W-1:0] oCnt_17,
  output logic             oTimeout,
  output logic             oOverrun,
  output logic             oBusy
);
  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  state_t          state;
  logic [1:0]      scale;
  logic            end_f;
  logic            quit;
  logic [WD_W-1:0] wdog;
  logic [2:0]      start_q;
  logic [2:0]      sel;
  logic            all_ready;
  logic            ready_sel;
  logic            clr;
  logic            disp;
  logic            wd_hit;
  assign sel       = scale_onehot(scale);
  assign all_ready = iReady_23 && iReady_19 && iReady_17;
  assign ready_sel = |(sel & {iReady_23, iReady_19, iReady_17});
  assign clr       = state == ST_IDLE && iFrame_start;
  assign disp      = state == ST_DISPATCH && ready_sel && !iAbort;
  assign wd_hit    = wdog == WD_W'(TIMEOUT_CYC - 1);
  assign {oStart_23, oStart_19, oStart_17} = start_q;
  // frame scheduler: abort preempts every busy state except RST, which is already tearing down
  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state       <= ST_IDLE;
      scale       <= 2'd0;
      end_f       <= 1'b0;
      quit        <= 1'b0;
      wdog        <= '0;
      start_q     <= 3'b0;
      oRun        <= 1'b0;
      oRst        <= 1'b0;
      oWin_addr   <= 13'd0;
      oFrame_done <= 1'b0;
      oTimeout    <= 1'b0;
      oOverrun    <= 1'b0;
      oBusy       <= 1'b0;
    end else begin
      start_q     <= 3'b0;
      oRst        <= 1'b0;
      oFrame_done <= 1'b0;
      if (iFrame_start) oTimeout <= 1'b0;
      if (iFrame_start && state != ST_IDLE) oOverrun <= 1'b1;
      if (iEnd && state inside {ST_ARM, ST_WAIT_FIN, ST_DISPATCH}) end_f <= 1'b1;
      if (iAbort && state != ST_IDLE && state != ST_RST) begin
        oRun  <= 1'b0;
        oRst  <= 1'b1;
        quit  <= 1'b1;
        oBusy <= 1'b1;
        state <= ST_RST;
      end else begin
        case (state)
          ST_IDLE: if (iFrame_start) begin
            oOverrun <= 1'b0;
            end_f    <= 1'b0;
            quit     <= 1'b0;
            oBusy    <= 1'b1;
            state    <= ST_ARM;
          end
          ST_ARM: if (all_ready) begin
            oRun  <= 1'b1;
            wdog  <= '0;
            state <= ST_WAIT_FIN;
          end
          ST_WAIT_FIN: if (iFinish != 2'd0) begin
            scale     <= iFinish;
            oWin_addr <= iAddr_OM;
            oRun      <= 1'b0;
            state     <= ST_DISPATCH;
          end else if (end_f || iEnd) begin
            oRun  <= 1'b0;
            state <= ST_DRAIN;
          end else if (wd_hit) begin
            oTimeout <= 1'b1;
            quit     <= 1'b1;
            oRun     <= 1'b0;
            oRst     <= 1'b1;
            state    <= ST_RST;
          end else begin
            wdog <= wdog + 1'b1;
          end
          ST_DISPATCH: if (ready_sel) begin
            start_q <= sel;
            state   <= (end_f || iEnd) ? ST_DRAIN : ST_ARM;
          end
          ST_DRAIN: if (all_ready) begin
            oRst  <= 1'b1;
            state <= ST_RST;
          end
          ST_RST: begin
            oFrame_done <= !quit;
            oBusy       <= !quit;
            state       <= quit ? ST_IDLE : ST_DONE;
          end
          ST_DONE: begin
            oBusy <= 1'b0;
            state <= ST_IDLE;
          end
          default: begin
            oBusy <= 1'b0;
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end
  iib_win_counter #(.W(CNT_W)) u_cnt_23 (
    .iClk(iClk), .iReset_n(iReset_n), .iClr(clr), .iInc(disp && sel[2]), .oCnt(oCnt_23)
  );
  iib_win_counter #(.W(CNT_W)) u_cnt_19 (
    .iClk(iClk), .iReset_n(iReset_n), .iClr(clr), .iInc(disp && sel[1]), .oCnt(oCnt_19)
  );
  iib_win_counter #(.W(CNT_W)) u_cnt_17 (
    .iClk(iClk), .iReset_n(iReset_n), .iClr(clr), .iInc(disp && sel[0]), .oCnt(oCnt_17)
  );
endmodule
